// File: rtl/fib_checker_if.sv
// Bus between the Fibonacci pattern source and its receive-side checker.
// master drives the sample stream; slave (the checker) returns lock/error status.
interface fib_checker_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  locked;
  logic                  err;
  logic [CNT_WIDTH-1:0]  err_count;
  logic [DATA_WIDTH-1:0] expected;

  modport master (
    output din,
    output din_valid,
    input  locked,
    input  err,
    input  err_count,
    input  expected
  );

  modport slave (
    input  din,
    input  din_valid,
    output locked,
    output err,
    output err_count,
    output expected
  );
endinterface

// File: rtl/fib_checker.sv
// Receive-side checker for the Fibonacci test-pattern generator: predicts a+b, locks, counts errors.
// Optional macro FIB_SEED_CHECK_EN: require seed samples of 1 in IDLE/PRIME until the first lock.
module fib_checker #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic          clk,
  input  logic          reset,
  fib_checker_if.slave  bus
);

  localparam logic [3:0] LOCK_LIMIT = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_LIMIT = 4'(LOSS_COUNT);

  typedef enum logic [1:0] {StIdle, StPrime, StSearch, StLocked} state_e;

  state_e                r_state, w_state_d;
  logic [DATA_WIDTH-1:0] r_a, r_b;
  logic [DATA_WIDTH-1:0] w_expected;
  logic [3:0]            r_run, w_run_d, w_run_inc;
  logic                  r_err, w_err_d;
  logic [CNT_WIDTH-1:0]  r_err_count, w_err_count_d, w_err_count_inc;
  logic                  w_match;
  logic                  w_seed_ok;
`ifdef FIB_SEED_CHECK_EN
  logic                  r_seeded, w_seeded_d;
`endif

  assign w_expected      = r_a + r_b;
  assign w_match         = (bus.din == w_expected);
  assign w_run_inc       = r_run + 4'd1;
  assign w_err_count_inc = (r_err_count == {CNT_WIDTH{1'b1}}) ? r_err_count : r_err_count + 1'b1;

`ifdef FIB_SEED_CHECK_EN
  // Seed rule applies only until the first lock after reset.
  assign w_seed_ok = r_seeded || (bus.din == DATA_WIDTH'(1));
`else
  assign w_seed_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_run       <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
`ifdef FIB_SEED_CHECK_EN
      r_seeded    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_run       <= w_run_d;
      r_err       <= w_err_d;
      r_err_count <= w_err_count_d;
`ifdef FIB_SEED_CHECK_EN
      r_seeded    <= w_seeded_d;
`endif
      // History shifts on every accepted sample, whatever the state.
      if (bus.din_valid) begin
        r_a <= r_b;
        r_b <= bus.din;
      end
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_run_d       = r_run;
    w_err_d       = 1'b0;
    w_err_count_d = r_err_count;
`ifdef FIB_SEED_CHECK_EN
    w_seeded_d    = r_seeded;
`endif
    if (bus.din_valid) begin
      unique case (r_state)
        StIdle: begin
          if (!w_seed_ok) begin
            w_err_d       = 1'b1;
            w_err_count_d = w_err_count_inc;
          end else begin
            w_state_d = StPrime;
          end
        end
        StPrime: begin
          if (!w_seed_ok) begin
            w_err_d       = 1'b1;
            w_err_count_d = w_err_count_inc;
            w_state_d     = StIdle;
          end else begin
            w_state_d = StSearch;
            w_run_d   = '0;
          end
        end
        StSearch: begin
          if (w_match) begin
            if (w_run_inc == LOCK_LIMIT) begin
              w_state_d  = StLocked;
              w_run_d    = '0;
`ifdef FIB_SEED_CHECK_EN
              w_seeded_d = 1'b1;
`endif
            end else begin
              w_run_d = w_run_inc;
            end
          end else begin
            w_run_d = '0;
          end
        end
        StLocked: begin
          if (w_match) begin
            w_run_d = '0;
          end else begin
            w_err_d       = 1'b1;
            w_err_count_d = w_err_count_inc;
            if (w_run_inc == LOSS_LIMIT) begin
              w_state_d = StSearch;
              w_run_d   = '0;
            end else begin
              w_run_d = w_run_inc;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bus.locked    = (r_state == StLocked);
    bus.err       = r_err;
    bus.err_count = r_err_count;
    bus.expected  = w_expected;
  end

endmodule

// File: tb/tb_fib_checker.sv
// Self-checking bench for fib_checker: directed scenarios plus a randomized corrupted stream,
// compared every cycle against a sample-level behavioural model.
module tb_fib_checker;

  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int LOCKN = 4;
  localparam int LOSSN = 3;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;

  fib_checker_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  fib_checker #(
    .DATA_WIDTH (DW),
    .LOCK_COUNT (LOCKN),
    .LOSS_COUNT (LOSSN),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Model: phase 0 = waiting for first sample, 1 = second, 2 = hunting, 3 = locked.
  int m_phase, m_a, m_b, m_streak, m_cnt;
  bit m_err, m_seen;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic mdl_reset();
    m_phase = 0; m_a = 0; m_b = 0; m_streak = 0; m_cnt = 0; m_err = 0; m_seen = 0;
  endtask

  function automatic bit seed_bad(input int d);
`ifdef FIB_SEED_CHECK_EN
    return !m_seen && d != 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic count_err();
    m_err = 1;
    if (m_cnt < CMAX) m_cnt++;
  endtask

  task automatic mdl_sample(input int d);
    int  pred;
    bit  bad;
    pred  = (m_a + m_b) % (1 << DW);
    bad   = seed_bad(d);
    m_err = 0;
    if (m_phase == 0) begin
      if (bad) count_err(); else m_phase = 1;
    end else if (m_phase == 1) begin
      if (bad) begin count_err(); m_phase = 0; end
      else begin m_phase = 2; m_streak = 0; end
    end else if (m_phase == 2) begin
      m_streak = (d == pred) ? m_streak + 1 : 0;
      if (m_streak == LOCKN) begin m_phase = 3; m_streak = 0; m_seen = 1; end
    end else begin
      if (d == pred) m_streak = 0;
      else begin
        count_err();
        m_streak++;
        if (m_streak == LOSSN) begin m_phase = 2; m_streak = 0; end
      end
    end
    m_a = m_b;
    m_b = d;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("locked", int'(bus.locked), int'(m_phase == 3));
      check("err", int'(bus.err), int'(m_err));
      check("err_count", int'(bus.err_count), m_cnt);
      if (m_phase >= 2) check("expected", int'(bus.expected), (m_a + m_b) % (1 << DW));
    end
  end

  task automatic step(input bit v, input int d, input bit r);
    reset         = r;
    bus.din_valid = v;
    bus.din       = DW'(d);
    @(posedge clk);
    if (r) mdl_reset();
    else if (v) mdl_sample(d);
    else m_err = 0;
    @(negedge clk);
  endtask

  task automatic feed(input int d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 0, 1'b1);
  endtask

  int fib7[7] = '{1, 1, 2, 3, 5, 8, 13};
  int tail[7] = '{21, 34, 55, 89, 144, 233, 121};

  initial begin
    int g0, g1, w, t;
    bit v;
    reset = 1'b1;
    bus.din = '0;
    bus.din_valid = 1'b0;
    mdl_reset();
    @(negedge clk);
    do_reset();
    chk_on = 1'b1;
    check("rst_locked", int'(bus.locked), 0);
    check("rst_err_count", int'(bus.err_count), 0);
    check("rst_expected", int'(bus.expected), 0);

    // Lock after four matches: 2, 3, 5, 8.
    for (int i = 0; i < 5; i++) feed(fib7[i]);
    check("s1_not_yet_locked", int'(bus.locked), 0);
    feed(8);
    check("s1_locked", int'(bus.locked), 1);
    feed(13);

    // Wrap-around terms.
    for (int i = 0; i < 6; i++) feed(tail[i]);
    check("s2_expected_121", int'(bus.expected), 121);
    feed(121);
    check("s2_expected_98", int'(bus.expected), 98);
    check("s2_err_count", int'(bus.err_count), 0);

    // Corrupt word 99 stays in history for two predictions: three counted, lock lost.
    feed(99);
    check("s3_err_99", int'(bus.err), 1);
    check("s3_expected_220", int'(bus.expected), 220);
    feed(219);
    check("s3_cnt_2", int'(bus.err_count), 2);
    feed(61);
    check("s3_cnt_3", int'(bus.err_count), 3);
    check("s3_unlocked", int'(bus.locked), 0);
    feed(24); feed(85); feed(109); feed(194);
    check("s3_relocked", int'(bus.locked), 1);

    // Three wrong words in LOCKED, then re-lock.
    feed(0); feed(0); feed(7);
    check("s4_cnt_6", int'(bus.err_count), 6);
    check("s4_unlocked", int'(bus.locked), 0);
    for (int i = 0; i < 6; i++) feed(fib7[i]);
    check("s4_relocked", int'(bus.locked), 1);
    check("s4_cnt_hold", int'(bus.err_count), 6);

    do_reset();
    check("s6_locked", int'(bus.locked), 0);
    check("s6_cnt", int'(bus.err_count), 0);

    // Idle gaps with garbage on din.
    for (int i = 0; i < 7; i++) begin
      feed(fib7[i]);
      repeat (5) step(1'b0, int'($urandom_range(0, 255)), 1'b0);
    end
    check("s5_locked", int'(bus.locked), 1);
    check("s5_cnt", int'(bus.err_count), 0);

    do_reset();
    feed(7);
`ifdef FIB_SEED_CHECK_EN
    check("seed_err", int'(bus.err), 1);
    check("seed_cnt", int'(bus.err_count), 1);
`else
    check("seed_err", int'(bus.err), 0);
    check("seed_cnt", int'(bus.err_count), 0);
`endif

    // Saturation: 6 x 3 counted mismatches into a 4-bit counter.
    do_reset();
    repeat (6) begin
      for (int i = 0; i < 6; i++) feed(fib7[i]);
      feed(200); feed(201); feed(202);
    end
    check("sat_cnt", int'(bus.err_count), CMAX);

    // Randomized generator stream with corruptions, gaps and occasional resets.
    do_reset();
    g0 = 1; g1 = 1;
    for (int i = 0; i < 3000; i++) begin
      t = int'($urandom_range(0, 399));
      if (t == 0) begin
        do_reset();
        g0 = 1; g1 = 1;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        if (v) begin
          w = g0;
          if ($urandom_range(0, 24) == 0) w = int'($urandom_range(0, 255));
          g1 = (g0 + g1) % 256;
          g0 = (g1 - g0 + 256) % 256;
          feed(w);
        end else begin
          step(1'b0, int'($urandom_range(0, 255)), 1'b0);
        end
      end
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
